// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: round-robin sharing of one 8-bit ALU, owning the {C,S,V,Z} flag register
module alu_exec_ctrl #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [4*NUM_REQ-1:0] req_op,
   input  logic [8*NUM_REQ-1:0] req_a,
   input  logic [8*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]   req_flag_we,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [7:0]           rsp_result,
   output logic [3:0]           rsp_status,
   output logic                 rsp_err,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic [3:0]           alu_op,
   output logic [3:0]           alu_status_in,
   input  logic [7:0]           alu_result,
   input  logic [3:0]           alu_status,
   output logic [3:0]           flags_q
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_n;
   logic [ID_W-1:0] ptr, win;
   logic [3:0] op_q;
   logic [7:0] a_q, b_q;
   logic we_q, found, fire, err;
   logic [2*NUM_REQ-1:0] rot;
   int w;
   // rotate so bit 0 is the requester just after the last winner
   always_comb begin
      rot = {req_valid, req_valid} >> (int'(ptr) + 1);
      found = 1'b0;
      w = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (rot[k]) begin
            found = 1'b1;
            w = (int'(ptr) + 1 + k) % NUM_REQ;
         end
   end
   assign win = ID_W'(w);
   assign req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << win) : '0;
   assign fire = |(req_valid & req_ready);
   assign err = !(op_q inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC});
   assign rsp_valid = (state == RESP);
   assign alu_a = a_q;
   assign alu_b = b_q;
   assign alu_op = op_q;
   assign alu_status_in = flags_q;
   always_comb begin
      state_n = state;
      if (state == IDLE && fire) state_n = EXEC;
      else if (state == EXEC) state_n = RESP;
      else if (state == RESP && rsp_ready) state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= ID_W'(NUM_REQ - 1);
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         we_q       <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_status <= '0;
         rsp_err    <= 1'b0;
         flags_q    <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && fire) begin
            op_q   <= req_op[win*4 +: 4];
            a_q    <= req_a[win*8 +: 8];
            b_q    <= req_b[win*8 +: 8];
            we_q   <= req_flag_we[win];
            rsp_id <= win;
            ptr    <= win;
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_status <= alu_status;
            rsp_err    <= err;
            if (we_q && !err) flags_q <= alu_status;
         end
      end
   end
endmodule
